// File: rtl/adau1761_codec_ctrl.sv
// ---------------------------------------------------------------------------
// adau1761_codec_ctrl
//   Control-side front end for the ADAU1761 codec on the Zedboard.
//   - Divides clk_48 by two to produce the codec master clock (24 MHz).
//   - After reset and a start-up idle time, an I2C write master loads a
//     fixed 18-entry register table into the codec. Each entry is one
//     transfer: START, 8'h76, reg_hi, reg_lo, data, STOP, then a bus gap.
//   - A NACK on any byte sets the sticky flag active[1], ends the transfer
//     with STOP and retries the same entry. There is no retry limit.
//   - The line-in gain (registers 400B/400D) is taken from sw, which is
//     sampled when each entry starts.
//
// Optional feature, selected by the macro SW_UPDATE_EN:
//   When it is defined, sw is watched in the DONE state. A change rewrites
//   400B and 400D with the new gain and then returns to DONE.
//   When it is not defined, DONE is terminal until rst.
//
// Ports
//   clk_48            in   48 MHz system clock
//   rst               in   asynchronous, active-high reset
//   sw[1:0]           in   line-in gain select
//   i2c_sda_i         in   SDA level from the IOBUF
//   i2c_sda_o         out  SDA drive value, constant 0 (open drain)
//   i2c_sda_t         out  1 = release SDA, 0 = drive SDA low
//   i2c_scl           out  SCL, push-pull
//   codec_master_clk  out  MCLK = clk_48 / 2
//   active[1:0]       out  [0] configuration done and idle, [1] NACK seen (sticky)
// ---------------------------------------------------------------------------
module adau1761_codec_ctrl #(
  parameter int         STARTUP_CYCLES = 480000,
  parameter int         I2C_QTR        = 120,
  parameter logic [6:0] DEV_ADDR       = 7'h3B
) (
  input  logic       clk_48,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  output logic       i2c_scl,
  output logic       codec_master_clk,
  output logic [1:0] active
);

  localparam int              QW         = (I2C_QTR > 1) ? $clog2(I2C_QTR) : 1;
  localparam logic [QW-1:0]   QTR_LAST   = QW'(I2C_QTR - 1);
  localparam logic [31:0]     WAIT_LAST  = 32'(STARTUP_CYCLES - 1);
  localparam logic [4:0]      LAST_ENTRY = 5'd17;
  localparam logic [4:0]      GAIN_B     = 5'd2;   // entry 400B <- G
  localparam logic [4:0]      GAIN_D     = 5'd4;   // entry 400D <- G

  typedef enum logic [2:0] {
    S_WAIT,
    S_START,
    S_SEND,
    S_STOP,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   wait_q, wait_d;
  logic [QW-1:0] qcnt_q, qcnt_d;     // clk_48 cycles inside the current quarter
  logic [1:0]    qtr_q, qtr_d;       // quarter q0..q3 of the current bit
  logic [3:0]    bit_q, bit_d;       // 0..7 data bits, 8 = ACK bit
  logic [1:0]    byte_q, byte_d;     // address, reg_hi, reg_lo, data
  logic [4:0]    entry_q, entry_d;
  logic [1:0]    gain_sw_q, gain_sw_d;
  logic          nack_q, nack_d;     // NACK in the current transfer
  logic          nack_seen_q, nack_seen_d;
  logic          upd_q, upd_d;       // gain-only rewrite in progress
  logic          scl_q, scl_d;
  logic          sdat_q, sdat_d;
  logic          mclk_q;
  logic [1:0]    sw_s1_q, sw_s2_q;   // sw is asynchronous to clk_48
`ifdef SW_UPDATE_EN
  logic [1:0]    sw_wr_q, sw_wr_d;   // sw value used for the last gain write
`endif

  logic          qtr_end;
  logic          bit_end;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] gain_code(input logic [1:0] g);
    case (g)
      2'b00:   gain_code = 8'h05;
      2'b01:   gain_code = 8'h07;
      2'b10:   gain_code = 8'h0B;
      default: gain_code = 8'h0F;
    endcase
  endfunction

  function automatic logic [15:0] entry_reg(input logic [4:0] idx);
    case (idx)
      5'd0:    entry_reg = 16'h4000;
      5'd1:    entry_reg = 16'h400A;
      5'd2:    entry_reg = 16'h400B;
      5'd3:    entry_reg = 16'h400C;
      5'd4:    entry_reg = 16'h400D;
      5'd5:    entry_reg = 16'h401C;
      5'd6:    entry_reg = 16'h401E;
      5'd7:    entry_reg = 16'h4023;
      5'd8:    entry_reg = 16'h4024;
      5'd9:    entry_reg = 16'h4025;
      5'd10:   entry_reg = 16'h4026;
      5'd11:   entry_reg = 16'h4019;
      5'd12:   entry_reg = 16'h4029;
      5'd13:   entry_reg = 16'h402A;
      5'd14:   entry_reg = 16'h40F2;
      5'd15:   entry_reg = 16'h40F3;
      5'd16:   entry_reg = 16'h40F9;
      5'd17:   entry_reg = 16'h40FA;
      default: entry_reg = 16'h4000;
    endcase
  endfunction

  function automatic logic [7:0] entry_data(input logic [4:0] idx, input logic [1:0] g);
    case (idx)
      5'd0, 5'd1, 5'd3:  entry_data = 8'h01;
      5'd2, 5'd4:        entry_data = gain_code(g);
      5'd5:              entry_data = 8'h21;
      5'd6:              entry_data = 8'h41;
      5'd7, 5'd8,
      5'd9, 5'd10:       entry_data = 8'hE7;
      5'd11, 5'd12,
      5'd13, 5'd17:      entry_data = 8'h03;
      5'd14, 5'd15:      entry_data = 8'h01;
      5'd16:             entry_data = 8'h7F;
      default:           entry_data = 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] tx_byte(input logic [4:0] idx, input logic [1:0] bidx,
                                         input logic [1:0] g);
    logic [15:0] r;
    r = entry_reg(idx);
    case (bidx)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = r[15:8];
      2'd2:    tx_byte = r[7:0];
      default: tx_byte = entry_data(idx, g);
    endcase
  endfunction

  assign qtr_end = (qcnt_q == QTR_LAST);
  assign bit_end = qtr_end && (qtr_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    qcnt_d      = qcnt_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    entry_d     = entry_q;
    gain_sw_d   = gain_sw_q;
    nack_d      = nack_q;
    nack_seen_d = nack_seen_q;
    upd_d       = upd_q;
`ifdef SW_UPDATE_EN
    sw_wr_d     = sw_wr_q;
`endif
    scl_d       = 1'b1;
    sdat_d      = 1'b1;
    cur_byte    = 8'h00;

    // Every bus phase (START, bits, STOP, GAP) is four quarters long.
    if (state_q inside {S_START, S_SEND, S_STOP, S_GAP}) begin
      qcnt_d = qtr_end ? '0 : qcnt_q + QW'(1);
      if (qtr_end) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_START;
          entry_d = '0;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_SEND;
          bit_d   = 4'd0;
          byte_d  = 2'd0;
          nack_d  = 1'b0;
        end
      end
      S_SEND: begin
        // ACK is sampled once, on the first cycle of q3 of the ninth bit.
        if (bit_q == 4'd8 && qtr_q == 2'd3 && qcnt_q == '0 && i2c_sda_i) begin
          nack_d      = 1'b1;
          nack_seen_d = 1'b1;
        end
        if (bit_end) begin
          if (bit_q == 4'd8) begin
            if (nack_d || byte_q == 2'd3) begin
              state_d = S_STOP;
            end else begin
              byte_d = byte_q + 2'd1;
              bit_d  = 4'd0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) state_d = S_GAP;
      end
      S_GAP: begin
        if (bit_end) begin
          if (nack_q) begin
            state_d = S_START;               // retry the same entry
          end else if (upd_q) begin
            if (entry_q == GAIN_B) begin
              entry_d = GAIN_D;
              state_d = S_START;
            end else begin
              upd_d   = 1'b0;
              state_d = S_DONE;
            end
          end else if (entry_q == LAST_ENTRY) begin
            state_d = S_DONE;
          end else begin
            entry_d = entry_q + 5'd1;
            state_d = S_START;
          end
        end
      end
      S_DONE: begin
`ifdef SW_UPDATE_EN
        if (sw_s2_q != sw_wr_q) begin
          upd_d   = 1'b1;
          entry_d = GAIN_B;
          state_d = S_START;
        end
`endif
      end
      default: state_d = S_WAIT;
    endcase

    // Gain select is captured at the start of every entry, retries included.
    if (state_d == S_START && state_q != S_START) begin
      gain_sw_d = sw_s2_q;
`ifdef SW_UPDATE_EN
      if (entry_d == GAIN_D) sw_wr_d = sw_s2_q;
`endif
    end

    // Bus levels are derived from the next state so they line up with it
    // once registered. SDA only moves together with (or after) SCL falling,
    // except for the START fall and STOP rise below.
    cur_byte = tx_byte(entry_d, byte_d, gain_sw_d);
    case (state_d)
      S_START: sdat_d = ~qtr_d[1];
      S_SEND: begin
        scl_d  = qtr_d[1];
        sdat_d = (bit_d == 4'd8) ? 1'b1 : cur_byte[3'd7 - bit_d[2:0]];
      end
      S_STOP: begin
        scl_d  = qtr_d[1];
        sdat_d = (qtr_d == 2'd3);
      end
      default: begin
        scl_d  = 1'b1;
        sdat_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      wait_q      <= '0;
      qcnt_q      <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 4'd0;
      byte_q      <= 2'd0;
      entry_q     <= 5'd0;
      gain_sw_q   <= 2'b00;
      nack_q      <= 1'b0;
      nack_seen_q <= 1'b0;
      upd_q       <= 1'b0;
      scl_q       <= 1'b1;
      sdat_q      <= 1'b1;
      mclk_q      <= 1'b0;
      sw_s1_q     <= 2'b00;
      sw_s2_q     <= 2'b00;
`ifdef SW_UPDATE_EN
      sw_wr_q     <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      qcnt_q      <= qcnt_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      entry_q     <= entry_d;
      gain_sw_q   <= gain_sw_d;
      nack_q      <= nack_d;
      nack_seen_q <= nack_seen_d;
      upd_q       <= upd_d;
      scl_q       <= scl_d;
      sdat_q      <= sdat_d;
      mclk_q      <= ~mclk_q;
      sw_s1_q     <= sw;
      sw_s2_q     <= sw_s1_q;
`ifdef SW_UPDATE_EN
      sw_wr_q     <= sw_wr_d;
`endif
    end
  end

  assign i2c_sda_o        = 1'b0;
  assign i2c_sda_t        = sdat_q;
  assign i2c_scl          = scl_q;
  assign codec_master_clk = mclk_q;
  assign active           = {nack_seen_q, (state_q == S_DONE)};

endmodule

// File: tb/tb_adau1761_codec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adau1761_codec_ctrl
//   Bench for adau1761_codec_ctrl with short timing (STARTUP_CYCLES=10,
//   I2C_QTR=4). An I2C slave model decodes START/STOP and bytes from the
//   bus, ACKs every byte (optionally NACKs the first address byte once) and
//   logs each transfer. The log is compared with transfers built from the
//   codec register table and the gain code chosen by sw.
// ---------------------------------------------------------------------------
module tb_adau1761_codec_ctrl;

  localparam int STARTUP = 10;
  localparam int QTR     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw  = 2'b00;
  logic       sda_bus;
  logic       sda_o, sda_t, scl, mclk;
  logic [1:0] active;
  logic       ack_drv = 1'b0;

  always #5 clk = ~clk;

  // Open-drain bus with pull-up: either side may pull it low.
  assign sda_bus = (sda_t ? 1'b1 : sda_o) & ~ack_drv;

  adau1761_codec_ctrl #(
    .STARTUP_CYCLES(STARTUP),
    .I2C_QTR       (QTR),
    .DEV_ADDR      (7'h3B)
  ) dut (
    .clk_48          (clk),
    .rst             (rst),
    .sw              (sw),
    .i2c_sda_i       (sda_bus),
    .i2c_sda_o       (sda_o),
    .i2c_sda_t       (sda_t),
    .i2c_scl         (scl),
    .codec_master_clk(mclk),
    .active          (active)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference table (register, data); data 00 marks a gain entry.
  logic [15:0] regs [18] = '{16'h4000, 16'h400A, 16'h400B, 16'h400C, 16'h400D, 16'h401C,
                             16'h401E, 16'h4023, 16'h4024, 16'h4025, 16'h4026, 16'h4019,
                             16'h4029, 16'h402A, 16'h40F2, 16'h40F3, 16'h40F9, 16'h40FA};
  logic [7:0]  dats [18] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h21, 8'h41, 8'hE7, 8'hE7,
                             8'hE7, 8'hE7, 8'h03, 8'h03, 8'h03, 8'h01, 8'h01, 8'h7F, 8'h03};
  logic [7:0]  gains [4] = '{8'h05, 8'h07, 8'h0B, 8'h0F};

  // Transfer record: {byte count, byte0..byte3}.
  function automatic logic [34:0] exp_rec(input int idx, input logic [1:0] g);
    logic [7:0] d;
    d = (regs[idx] == 16'h400B || regs[idx] == 16'h400D) ? gains[g] : dats[idx];
    return {3'd4, 8'h76, regs[idx], d};
  endfunction

  // ---------------- slave model / bus monitor ----------------
  logic [34:0] rec_q [$];
  bit          nack_once = 1'b0;

  initial begin
    logic        prev_scl, prev_sda, in_xfer, nk;
    int          bitn, nb;
    logic [7:0]  sr;
    logic [31:0] bytes;
    prev_scl = 1'b1; prev_sda = 1'b1; in_xfer = 1'b0;
    bitn = 0; nb = 0; sr = 8'h00; bytes = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_scl = 1'b1; prev_sda = 1'b1; in_xfer = 1'b0;
        bitn = 0; nb = 0; ack_drv = 1'b0;
        rec_q.delete();
      end else begin
        if (prev_scl && scl && prev_sda && !sda_bus) begin
          chk("repeated_start", {63'd0, in_xfer}, 64'd0);
          chk("active0_busy", {63'd0, active[0]}, 64'd0);
          in_xfer = 1'b1; bitn = 0; nb = 0; bytes = 32'h0;
        end else if (prev_scl && scl && !prev_sda && sda_bus) begin
          if (in_xfer) rec_q.push_back({3'(nb), bytes});
          in_xfer = 1'b0;
        end else if (!prev_scl && scl && in_xfer) begin
          if (bitn < 8) begin
            sr = {sr[6:0], sda_bus};
            bitn++;
            if (bitn == 8) begin
              if (nb < 4) bytes[8*(3-nb) +: 8] = sr;
              nb++;
            end
          end else begin
            bitn = 9;
          end
        end else if (prev_scl && !scl && in_xfer) begin
          if (bitn == 8) begin
            nk = nack_once && (nb == 1);
            if (nk) nack_once = 1'b0;
            ack_drv = ~nk;
          end else if (bitn == 9) begin
            ack_drv = 1'b0;
            bitn = 0;
          end
        end
        prev_scl = scl;
        prev_sda = sda_bus;
      end
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!active[0] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {63'd0, active[0]}, 64'd1);
  endtask

  task automatic check_table(input string run, input int offset, input logic [1:0] g);
    for (int i = 0; i < 18; i++) begin
      if (i + offset < rec_q.size())
        chk($sformatf("%s_xfer%0d", run, i), {29'd0, rec_q[i+offset]}, {29'd0, exp_rec(i, g)});
    end
  endtask

  task automatic chk_reset_outputs(input string run);
    chk({run, "_scl"},    {63'd0, scl},    64'd1);
    chk({run, "_sda_t"},  {63'd0, sda_t},  64'd1);
    chk({run, "_sda_o"},  {63'd0, sda_o},  64'd0);
    chk({run, "_mclk"},   {63'd0, mclk},   64'd0);
    chk({run, "_active"}, {62'd0, active}, 64'd0);
  endtask

  initial begin
    logic [1:0] g, ng;
    logic       pm;
    int         n, base;

    // Run A: reset values, MCLK, sw=10 and one NACK on the first address byte.
    rst = 1'b1;
    sw  = 2'b10;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    nack_once = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    pm = mclk;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mclk_toggle", {63'd0, mclk}, {63'd0, ~pm});
      pm = mclk;
    end
    wait_done(20000);
    chk("A_xfer_count", rec_q.size(), 19);
    if (rec_q.size() > 0)
      chk("A_nack_xfer", {29'd0, rec_q[0]}, {29'd0, 3'd1, 8'h76, 24'h0});
    check_table("A", 1, 2'b10);
    chk("A_active", {62'd0, active}, 64'd3);

    // Run B: random gain, asynchronous reset in the middle of the sequence.
    g  = 2'($urandom_range(0, 3));
    sw = g;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (rec_q.size() < 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("B_progress", {63'd0, (rec_q.size() >= 3)}, 64'd1);
    repeat ($urandom_range(20, 120)) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("arst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_done(20000);
    chk("B_xfer_count", rec_q.size(), 18);
    check_table("B", 0, g);
    chk("B_active", {62'd0, active}, 64'd1);

    // sw change after DONE.
    ng   = g ^ 2'($urandom_range(1, 3));
    base = rec_q.size();
    sw   = ng;
`ifdef SW_UPDATE_EN
    n = 0;
    while (active[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("upd_active0_drop", {63'd0, active[0]}, 64'd0);
    wait_done(5000);
    repeat (5) @(negedge clk);
    chk("upd_xfer_count", rec_q.size() - base, 2);
    if (rec_q.size() >= base + 2) begin
      chk("upd_400B", {29'd0, rec_q[base]},   {29'd0, exp_rec(2, ng)});
      chk("upd_400D", {29'd0, rec_q[base+1]}, {29'd0, exp_rec(4, ng)});
    end
    chk("upd_active", {62'd0, active}, 64'd1);
`else
    repeat (600) @(negedge clk);
    chk("noupd_xfer_count", rec_q.size() - base, 0);
    chk("noupd_active", {62'd0, active}, 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
